gamepad_n: RTL

GAMEPAD_N -- requirements
Module: gamepad_n

---
 rtl/gamepad_n_if.sv | 17 +
 rtl/gamepad_n.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/gamepad_n_if.sv
// Event stream from the gamepad bridge: head entry, occupancy and consumer pop strobe.
interface gamepad_n_if #(
  parameter int NUM_KEYS   = 6,
  parameter int FIFO_DEPTH = 8
);
  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             valid;
  logic             ready;
  logic [KEY_W-1:0] key;
  logic             press;
  logic [CNT_W-1:0] count;

  modport master (output valid, key, press, count, input ready);
  modport slave  (input valid, key, press, count, output ready);
endinterface

// File: rtl/gamepad_n.sv
// Remote gamepad bridge: polls a socket-line decoder, debounces keys (GAMEPAD_N_DEBOUNCE_EN),
// queues press/release events and reports LED changes back to the server.
module gamepad_n #(
  parameter int NUM_KEYS        = 6,
  parameter int NUM_LEDS        = 2,
  parameter int POLL_CYCLES     = 100,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 8,
  // ASCII strings, right-aligned and zero-padded on the left
  parameter logic [8*32-1:0] SOCK_ADDR  = "tcp://localhost:1080",
  parameter logic [8*16-1:0] SRV_PREFIX = "[gamepad]-"
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_LEDS-1:0]   led_i,
  output logic [NUM_KEYS-1:0]   key_o,
  output logic                  link_up_o,
  gamepad_n_if.master           evt,
  // socket side: the transport opens SOCK_ADDR once and splits each received line
  input  logic                  sock_open_i,
  output logic [8*32-1:0]       sock_addr_o,
  output logic                  line_req_o,
  input  logic                  line_valid_i,
  input  logic [8*16-1:0]       line_prefix_i,
  input  logic                  line_parse_ok_i,
  input  logic [NUM_KEYS-1:0]   line_mask_i,
  input  logic [NUM_KEYS-1:0]   line_val_i,
  output logic                  tx_valid_o,
  output logic [8*16-1:0]       tx_prefix_o,
  output logic [NUM_LEDS-1:0]   tx_led_o
);
  localparam int KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int POLL_W = $clog2(POLL_CYCLES);

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || NUM_LEDS < 1 || NUM_LEDS > 8 || POLL_CYCLES < 2 ||
      DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("gamepad_n: parameter out of range");
  end

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             press;
  } evt_t;

  logic [POLL_W-1:0]   poll_cnt;
  logic                tick;
  logic                line_ok;
  logic [NUM_KEYS-1:0] raw;
  logic [NUM_LEDS-1:0] last_sent;

  assign tick        = sock_open_i && (poll_cnt == POLL_W'(POLL_CYCLES - 1));
  assign line_ok     = line_valid_i && line_parse_ok_i && (line_prefix_i == SRV_PREFIX);
  assign line_req_o  = tick;
  assign tx_valid_o  = tick && (led_i != last_sent);
  assign tx_led_o    = led_i;
  assign tx_prefix_o = SRV_PREFIX;
  assign sock_addr_o = SOCK_ADDR;

  // The poll counter only runs while the socket is open, so a failed open never ticks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      poll_cnt  <= '0;
      link_up_o <= 1'b0;
      raw       <= '0;
      last_sent <= '0;
    end else begin
      link_up_o <= sock_open_i;
      if (sock_open_i) poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
      if (tick && line_ok) raw <= (raw & ~line_mask_i) | (line_val_i & line_mask_i);
      if (tx_valid_o) last_sent <= led_i;
    end
  end

`ifdef GAMEPAD_N_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [DB_W-1:0] db_cnt [NUM_KEYS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_o <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (raw[i] == key_o[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          key_o[i]  <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) key_o <= '0;
    else       key_o <= raw;
  end
`endif

  logic [NUM_KEYS-1:0] rep;
  logic [NUM_KEYS-1:0] pending;
  logic [KEY_W-1:0]    sel;
  logic                push, pop, full;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  evt_t                mem [FIFO_DEPTH];
  evt_t                head;

  assign pending = key_o ^ rep;

  // NOTE: sel gets a value before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    sel = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) sel = KEY_W'(i);
    end
  end

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign pop  = evt.valid && evt.ready;
  assign push = (|pending) && (!full || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rep    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        rep[sel] <= key_o[sel];
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{key: sel, press: key_o[sel]};
  end

  assign head      = mem[rd_ptr];
  assign evt.valid = (count != '0);
  assign evt.key   = head.key;
  assign evt.press = head.press;
  assign evt.count = count;
endmodule
